// File: rtl/custom_sync_fifo_ctrl_if.sv
// Request/status bundle between a FIFO user (master) and the FIFO pointer/flag controller (slave).
interface custom_sync_fifo_ctrl_if #(
    parameter int ADDRSIZE = 4
);
    logic                wen;
    logic                ren;
    logic                clr_err;
    logic [ADDRSIZE:0]   af_thresh;
    logic [ADDRSIZE:0]   ae_thresh;
    logic [ADDRSIZE-1:0] wr_addr;
    logic [ADDRSIZE-1:0] rd_addr;
    logic [ADDRSIZE:0]   wptr_g;
    logic [ADDRSIZE:0]   rptr_g;
    logic [ADDRSIZE:0]   count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_almost_full;
    logic                fifo_almost_empty;
    logic                overflow;
    logic                underflow;

    modport master (
        output wen, ren, clr_err, af_thresh, ae_thresh,
        input  wr_addr, rd_addr, wptr_g, rptr_g, count,
               fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty,
               overflow, underflow
    );

    modport slave (
        input  wen, ren, clr_err, af_thresh, ae_thresh,
        output wr_addr, rd_addr, wptr_g, rptr_g, count,
               fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty,
               overflow, underflow
    );
endinterface

// File: rtl/custom_sync_fifo_ctrl.sv
// Synchronous FIFO controller: binary/Gray pointers, occupancy count, status flags
// and sticky overflow/underflow errors, all registered on clk_i.
module custom_sync_fifo_ctrl #(
    parameter int ADDRSIZE = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    custom_sync_fifo_ctrl_if.slave  fifo_if
);
    localparam logic [ADDRSIZE:0] PTR_ONE = {{ADDRSIZE{1'b0}}, 1'b1};

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] rbin_q, rbin_d;
    logic [ADDRSIZE:0] wptr_g_q, wptr_g_d;
    logic [ADDRSIZE:0] rptr_g_q, rptr_g_d;
    logic [ADDRSIZE:0] count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              wacc;
    logic              racc;

    // Accepts are qualified only by registered flags, so no input reaches an output combinationally.
    always_comb begin
        wacc     = fifo_if.wen & ~full_q;
        racc     = fifo_if.ren & ~empty_q;
        wbin_d   = wacc ? wbin_q + PTR_ONE : wbin_q;
        rbin_d   = racc ? rbin_q + PTR_ONE : rbin_q;
        wptr_g_d = wbin_d ^ (wbin_d >> 1);
        rptr_g_d = rbin_d ^ (rbin_d >> 1);
        count_d  = wbin_d - rbin_d;
        full_d   = (wbin_d[ADDRSIZE] != rbin_d[ADDRSIZE]) &&
                   (wbin_d[ADDRSIZE-1:0] == rbin_d[ADDRSIZE-1:0]);
        empty_d  = (wbin_d == rbin_d);
        afull_d  = (count_d >= fifo_if.af_thresh);
        aempty_d = (count_d <= fifo_if.ae_thresh);
        ovf_d    = (fifo_if.wen & full_q)  | (ovf_q & ~fifo_if.clr_err);
        unf_d    = (fifo_if.ren & empty_q) | (unf_q & ~fifo_if.clr_err);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wbin_q   <= '0;
            rbin_q   <= '0;
            wptr_g_q <= '0;
            rptr_g_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            rbin_q   <= rbin_d;
            wptr_g_q <= wptr_g_d;
            rptr_g_q <= rptr_g_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign fifo_if.wr_addr           = wbin_q[ADDRSIZE-1:0];
    assign fifo_if.rd_addr           = rbin_q[ADDRSIZE-1:0];
    assign fifo_if.wptr_g            = wptr_g_q;
    assign fifo_if.rptr_g            = rptr_g_q;
    assign fifo_if.count             = count_q;
    assign fifo_if.fifo_full         = full_q;
    assign fifo_if.fifo_empty        = empty_q;
    assign fifo_if.fifo_almost_full  = afull_q;
    assign fifo_if.fifo_almost_empty = aempty_q;
    assign fifo_if.overflow          = ovf_q;
    assign fifo_if.underflow         = unf_q;
endmodule

// File: tb/tb_custom_sync_fifo_ctrl.sv
// Randomized bench for custom_sync_fifo_ctrl (ADDRSIZE=2) against an occupancy-level
// reference model, preceded by directed fill/full/empty/wrap/reset scenarios.
module tb_custom_sync_fifo_ctrl;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int MOD   = 8;

    logic clk = 1'b0;
    logic rstN;

    always #5 clk = ~clk;

    custom_sync_fifo_ctrl_if #(.ADDRSIZE(AW)) fifoIf ();

    custom_sync_fifo_ctrl #(.ADDRSIZE(AW)) dut (
        .clk_i   (clk),
        .rst_n_i (rstN),
        .fifo_if (fifoIf)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: number of items written/read so far and stored count.
    int mWr, mRd, mCount;
    bit mOvf, mUnf, mAf, mAe;

    function automatic int toGray(int b);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic compareAll();
        checkOutput("count",    32'(fifoIf.count),             32'(mCount));
        checkOutput("full",     32'(fifoIf.fifo_full),         32'(mCount == DEPTH));
        checkOutput("empty",    32'(fifoIf.fifo_empty),        32'(mCount == 0));
        checkOutput("afull",    32'(fifoIf.fifo_almost_full),  32'(mAf));
        checkOutput("aempty",   32'(fifoIf.fifo_almost_empty), 32'(mAe));
        checkOutput("overflow", 32'(fifoIf.overflow),          32'(mOvf));
        checkOutput("underflow",32'(fifoIf.underflow),         32'(mUnf));
        checkOutput("wr_addr",  32'(fifoIf.wr_addr),           32'(mWr % DEPTH));
        checkOutput("rd_addr",  32'(fifoIf.rd_addr),           32'(mRd % DEPTH));
        checkOutput("wptr_g",   32'(fifoIf.wptr_g),            32'(toGray(mWr)));
        checkOutput("rptr_g",   32'(fifoIf.rptr_g),            32'(toGray(mRd)));
    endtask

    task automatic applyStimulus(input bit rst, input bit w, input bit r, input bit clr,
                                 input int afT, input int aeT);
        bit wasFull, wasEmpty;
        @(negedge clk);
        rstN             = ~rst;
        fifoIf.wen       = w;
        fifoIf.ren       = r;
        fifoIf.clr_err   = clr;
        fifoIf.af_thresh = 3'(afT);
        fifoIf.ae_thresh = 3'(aeT);
        @(posedge clk);
        if (rst) begin
            mWr = 0; mRd = 0; mCount = 0;
            mOvf = 0; mUnf = 0; mAf = 0; mAe = 1;
        end else begin
            wasFull  = (mCount == DEPTH);
            wasEmpty = (mCount == 0);
            mOvf = (w && wasFull)  || (mOvf && !clr);
            mUnf = (r && wasEmpty) || (mUnf && !clr);
            if (w && !wasFull)  begin mWr = (mWr + 1) % MOD; mCount++; end
            if (r && !wasEmpty) begin mRd = (mRd + 1) % MOD; mCount--; end
            mAf = (mCount >= afT);
            mAe = (mCount <= aeT);
        end
        #1;
        compareAll();
    endtask

    initial begin
        logic [AW:0] prevW, prevR;
        rstN = 1'b0;
        fifoIf.wen = 0; fifoIf.ren = 0; fifoIf.clr_err = 0;
        fifoIf.af_thresh = 3; fifoIf.ae_thresh = 1;

        // Reset then fill to full.
        applyStimulus(1, 0, 0, 0, 3, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 3, 1);
        checkOutput("fill_wptr_g", 32'(fifoIf.wptr_g), 32'b110);

        // Write while full, then clear the error.
        applyStimulus(0, 1, 0, 0, 3, 1);
        applyStimulus(0, 0, 0, 1, 3, 1);
        checkOutput("ovf_cleared", 32'(fifoIf.overflow), 0);

        // Full with both requests: only the read goes through.
        applyStimulus(0, 1, 1, 0, 3, 1);
        checkOutput("full_both_count", 32'(fifoIf.count), 3);

        // Empty with both requests: only the write goes through.
        applyStimulus(1, 0, 0, 0, 3, 1);
        applyStimulus(0, 0, 1, 0, 3, 1);
        applyStimulus(0, 1, 1, 0, 3, 1);
        checkOutput("empty_both_count", 32'(fifoIf.count), 1);

        // Stream at count 2 so pointers wrap; Gray codes step by one bit.
        applyStimulus(0, 1, 0, 1, 3, 1);
        for (int i = 0; i < 20; i++) begin
            prevW = fifoIf.wptr_g;
            prevR = fifoIf.rptr_g;
            applyStimulus(0, 1, 1, 0, 3, 1);
            checkOutput("gray_w_step", 32'($countones(prevW ^ fifoIf.wptr_g)), 1);
            checkOutput("gray_r_step", 32'($countones(prevR ^ fifoIf.rptr_g)), 1);
        end

        // Reset mid-operation with a pending write.
        applyStimulus(0, 1, 0, 0, 3, 1);
        applyStimulus(1, 1, 0, 0, 3, 1);
        checkOutput("rst_mid_count", 32'(fifoIf.count), 0);

        // Randomized traffic with varying thresholds and occasional resets.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(39) == 0,
                          $urandom_range(1) == 1,
                          $urandom_range(1) == 1,
                          $urandom_range(7) == 0,
                          int'($urandom_range(7)),
                          int'($urandom_range(7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/custom_sync_fifo_ctrl.md
CUSTOM_SYNC_FIFO_CTRL -- requirements
Module: custom_sync_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRSIZE, default 4, meaning address width; depth DEPTH = 2**ADDRSIZE entries, legal range 2..16.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n_i  input  1  reset, synchronous and active-low.
REQ-004 wen  input  1  write request.
REQ-005 ren  input  1  read request.
REQ-006 af_thresh  input  ADDRSIZE+1  almost-full threshold (count >= af_thresh).
REQ-007 ae_thresh  input  ADDRSIZE+1  almost-empty threshold (count <= ae_thresh).
REQ-008 clr_err  input  1  clears sticky error flags.
REQ-009 wr_addr  output  ADDRSIZE  RAM write address (binary).
REQ-010 rd_addr  output  ADDRSIZE  RAM read address (binary).
REQ-011 wptr_g  output  ADDRSIZE+1  registered Gray-coded write pointer.
REQ-012 rptr_g  output  ADDRSIZE+1  registered Gray-coded read pointer.
REQ-013 count  output  ADDRSIZE+1  registered occupancy, 0..DEPTH.
REQ-014 fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty  output  1 each  registered status flags.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write accept wacc = wen & ~fifo_full; read accept racc = ren & ~fifo_empty; both use flag values registered in the current cycle.
REQ-017 Binary pointers wbin/rbin (ADDRSIZE+1 bits) SHALL increment by wacc/racc each cycle, wrapping modulo 2**(ADDRSIZE+1).
REQ-018 wr_addr = wbin[ADDRSIZE-1:0], rd_addr = rbin[ADDRSIZE-1:0]; both combinational from registered pointers.
REQ-019 wptr_g/rptr_g SHALL equal (next>>1)^next of the respective next binary pointer, registered in the same edge as the binary pointer (no extra latency).
REQ-020 count SHALL be registered as wbin_next - rbin_next (ADDRSIZE+1-bit modulo arithmetic), updating in the same edge as the accepted operation.
REQ-021 fifo_full SHALL be registered as (wbin_next[ADDRSIZE] != rbin_next[ADDRSIZE]) && equal lower bits; fifo_empty as wbin_next == rbin_next.
REQ-022 fifo_almost_full SHALL be registered as count_next >= af_thresh; fifo_almost_empty as count_next <= ae_thresh; af_thresh > DEPTH means never asserted, af_thresh = 0 means always asserted.
REQ-023 Simultaneous wacc and racc SHALL leave count and all flags unchanged while both pointers advance.
REQ-024 When full with wen and ren both high: read accepted, write rejected, count decrements, overflow set.
REQ-025 When empty with wen and ren both high: write accepted, read rejected, count increments, underflow set.
REQ-026 overflow SHALL set on wen & fifo_full; underflow on ren & fifo_empty; both hold until clr_err; set has priority over clr_err in the same cycle.
REQ-027 Flags SHALL reflect state one edge after the causing request; no combinational path from wen/ren to any output.

Reset
REQ-028 rst_n_i low at a rising edge SHALL force wbin, rbin, wptr_g, rptr_g, count, wr_addr, rd_addr to 0.
REQ-029 Reset values: fifo_empty = 1, fifo_full = 0, overflow = 0, underflow = 0, fifo_almost_empty = 1, fifo_almost_full = 0.
REQ-030 Reset mid-operation SHALL discard all occupancy; requests presented during the reset cycle SHALL be ignored and SHALL NOT set error flags.
REQ-031 Reset asserted without a clock edge SHALL have no effect.

Verification (ADDRSIZE=2, DEPTH=4, af_thresh=3, ae_thresh=1)
REQ-032 Reset, then 4 writes -> count 1,2,3,4; almost_empty drops after 2nd write; almost_full rises after 3rd write; full after 4th; wptr_g = 3'b110.
REQ-033 Full, wen=1 one cycle -> wbin unchanged, overflow=1; clr_err with wen=0 -> overflow=0 next edge.
REQ-034 Full, wen=ren=1 -> count 3, full=0, rd_addr advances by 1, wr_addr unchanged.
REQ-035 After reset, ren=1 -> underflow=1, rbin unchanged; wen=ren=1 -> count 1, empty=0.
REQ-036 Stream 20 simultaneous write/read cycles at count 2 -> count stays 2, pointers wrap past 7 to 0, Gray outputs change one bit per increment.
REQ-037 Assert rst_n_i low at count 3 with wen=1 -> next edge count 0, empty=1, overflow=0, all pointers 0.
